// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// valid/ready memory port, drives datapath enables/selects and counts retirements.
module rv_multicycle_ctrl #(
    parameter int ALUSEL_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         inst,
    input  logic                BrEq,
    input  logic                BrLt,
    input  logic                mem_ready,
    output logic                mem_valid,
    output logic                MemRW,
    output logic                IRWrite,
    output logic                MDRWrite,
    output logic                PCWrite,
    output logic                PCSel,
    output logic                Asel,
    output logic                Bsel,
    output logic [2:0]          ImmSel,
    output logic [ALUSEL_W-1:0] ALUSel,
    output logic                RegWEn,
    output logic [1:0]          WBSel,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {OP_R, OP_I, OP_LW, OP_SW, OP_LUI, OP_BR, OP_JAL, OP_BAD} op_t;

    state_t           r_state;
    op_t              r_op;
    logic [2:0]       r_f3;
    logic [3:0]       r_alu;
    logic             r_run;
    logic [CNT_W-1:0] r_instret;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    op_t        w_op;
    logic [3:0] w_alu;
    logic       w_taken;
    logic       w_retire;
    logic       w_unused;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign w_unused = ^{inst[24:15], inst[11:7]};

    function automatic logic [3:0] alu_of(input logic [2:0] f3);
        case (f3)
            3'b100:  alu_of = 4'b0100;
            3'b110:  alu_of = 4'b0001;
            3'b111:  alu_of = 4'b0000;
            3'b010:  alu_of = 4'b0111;
            default: alu_of = 4'b0010;
        endcase
    endfunction

    always_comb begin
        w_op  = OP_BAD;
        w_alu = 4'b0010;
        case (w_opcode)
            7'b0110011: begin
                if (w_f7 == 7'b0000000 && (w_f3 inside {3'b000, 3'b100, 3'b110, 3'b111, 3'b010})) begin
                    w_op  = OP_R;
                    w_alu = alu_of(w_f3);
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_op  = OP_R;
                    w_alu = 4'b0110;
                end
            end
            7'b0010011: begin
                if (w_f3 inside {3'b000, 3'b100, 3'b110, 3'b111, 3'b010}) begin
                    w_op  = OP_I;
                    w_alu = alu_of(w_f3);
                end
            end
            7'b0000011: if (w_f3 == 3'b010) w_op = OP_LW;
            7'b0100011: if (w_f3 == 3'b010) w_op = OP_SW;
            7'b0110111: begin
                w_op  = OP_LUI;
                w_alu = 4'b0011;
            end
            7'b1100011: if (w_f3 inside {3'b000, 3'b001, 3'b100, 3'b101}) w_op = OP_BR;
            7'b1101111: w_op = OP_JAL;
            default:    w_op = OP_BAD;
        endcase
    end

    always_comb begin
        case (r_f3)
            3'b000:  w_taken = BrEq;
            3'b001:  w_taken = !BrEq;
            3'b100:  w_taken = BrLt;
            3'b101:  w_taken = !BrLt;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_retire = (r_state == S_WB)
                   || (r_state == S_EXEC && (r_op == OP_BR || r_op == OP_JAL))
                   || (r_state == S_MEM && r_op == OP_SW && mem_ready);

    // r_run holds off the first memory request until one clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= OP_BAD;
            r_f3      <= 3'b000;
            r_alu     <= 4'b0000;
            r_run     <= 1'b0;
            r_instret <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            case (r_state)
                S_FETCH:  if (r_run && mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= w_op;
                    r_f3    <= w_f3;
                    r_alu   <= w_alu;
                    r_state <= (w_op == OP_BAD) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_R, OP_I, OP_LUI: r_state <= S_WB;
                        OP_LW, OP_SW:       r_state <= S_MEM;
                        OP_BR, OP_JAL:      r_state <= S_FETCH;
                        default:            r_state <= S_TRAP;
                    endcase
                end
                S_MEM:    if (mem_ready) r_state <= (r_op == OP_LW) ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    assign instret = r_instret;

    always_comb begin
        mem_valid = 1'b0;
        MemRW     = 1'b0;
        IRWrite   = 1'b0;
        MDRWrite  = 1'b0;
        PCWrite   = 1'b0;
        PCSel     = 1'b0;
        Asel      = 1'b0;
        Bsel      = 1'b0;
        ImmSel    = 3'b000;
        ALUSel    = '0;
        RegWEn    = 1'b0;
        WBSel     = 2'b00;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_valid = r_run;
                MemRW     = r_run;
                IRWrite   = r_run && mem_ready;
            end
            S_EXEC: begin
                ALUSel = ALUSEL_W'(r_alu);
                Bsel   = (r_op != OP_R);
                case (r_op)
                    OP_SW:  ImmSel = 3'b001;
                    OP_LUI: ImmSel = 3'b010;
                    OP_BR: begin
                        ImmSel  = 3'b011;
                        Asel    = 1'b1;
                        PCWrite = 1'b1;
                        PCSel   = w_taken;
                    end
                    OP_JAL: begin
                        ImmSel  = 3'b100;
                        Asel    = 1'b1;
                        PCWrite = 1'b1;
                        PCSel   = 1'b1;
                        RegWEn  = 1'b1;
                        WBSel   = 2'b10;
                    end
                    default: ImmSel = 3'b000;
                endcase
            end
            S_MEM: begin
                mem_valid = 1'b1;
                MemRW     = (r_op == OP_LW);
                Bsel      = 1'b1;
                ALUSel    = ALUSEL_W'(4'b0010);
                ImmSel    = (r_op == OP_SW) ? 3'b001 : 3'b000;
                MDRWrite  = (r_op == OP_LW) && mem_ready;
                PCWrite   = (r_op == OP_SW) && mem_ready;
            end
            S_WB: begin
                RegWEn  = 1'b1;
                WBSel   = (r_op == OP_LW) ? 2'b00 : 2'b01;
                PCWrite = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: random and directed instruction streams with random
// wait states, checked cycle by cycle against an instruction-level model.
module tb_rv_multicycle_ctrl;

    localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_LUI = 5, C_BR = 6, C_JAL = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        BrEq = 1'b0, BrLt = 1'b0, mem_ready = 1'b0;

    logic mv_a, rw_a, ir_a, mdr_a, pcw_a, pcs_a, as_a, bs_a, rwe_a, ill_a;
    logic mv_b, rw_b, ir_b, mdr_b, pcw_b, pcs_b, as_b, bs_b, rwe_b, ill_b;
    logic [2:0]  imm_a, imm_b;
    logic [3:0]  alu_a, alu_b;
    logic [1:0]  wb_a, wb_b;
    logic [31:0] instret_a;
    logic [3:0]  instret_b;
    logic [18:0] vec_a, vec_b;

    int          n_chk = 0, n_fail = 0;
    logic [31:0] exp_instret = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.ALUSEL_W(4), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready),
        .mem_valid(mv_a), .MemRW(rw_a), .IRWrite(ir_a), .MDRWrite(mdr_a), .PCWrite(pcw_a),
        .PCSel(pcs_a), .Asel(as_a), .Bsel(bs_a), .ImmSel(imm_a), .ALUSel(alu_a),
        .RegWEn(rwe_a), .WBSel(wb_a), .illegal(ill_a), .instret(instret_a)
    );

    rv_multicycle_ctrl #(.ALUSEL_W(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .inst(inst), .BrEq(BrEq), .BrLt(BrLt), .mem_ready(mem_ready),
        .mem_valid(mv_b), .MemRW(rw_b), .IRWrite(ir_b), .MDRWrite(mdr_b), .PCWrite(pcw_b),
        .PCSel(pcs_b), .Asel(as_b), .Bsel(bs_b), .ImmSel(imm_b), .ALUSel(alu_b),
        .RegWEn(rwe_b), .WBSel(wb_b), .illegal(ill_b), .instret(instret_b)
    );

    assign vec_a = {mv_a, rw_a, ir_a, mdr_a, pcw_a, pcs_a, as_a, bs_a, imm_a, alu_a, rwe_a, wb_a, ill_a};
    assign vec_b = {mv_b, rw_b, ir_b, mdr_b, pcw_b, pcs_b, as_b, bs_b, imm_b, alu_b, rwe_b, wb_b, ill_b};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Packs an expected output set in the same order as vec_a/vec_b.
    function automatic logic [18:0] ev(input logic mv, rw, ir, mdr, pcw, pcs, asl, bsl,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic rwe, input logic [1:0] wb, input logic ill);
        return {mv, rw, ir, mdr, pcw, pcs, asl, bsl, imm, alu, rwe, wb, ill};
    endfunction

    function automatic int classify(input logic [31:0] w);
        logic [9:0] f73;
        f73 = {w[31:25], w[14:12]};
        case (w[6:0])
            7'h33: return (f73 inside {10'h000, 10'h004, 10'h006, 10'h007, 10'h002, 10'h100}) ? C_R : C_ILL;
            7'h13: return (w[14:12] inside {3'd0, 3'd4, 3'd6, 3'd7, 3'd2}) ? C_I : C_ILL;
            7'h03: return (w[14:12] == 3'd2) ? C_LW : C_ILL;
            7'h23: return (w[14:12] == 3'd2) ? C_SW : C_ILL;
            7'h37: return C_LUI;
            7'h63: return (w[14:12] inside {3'd0, 3'd1, 3'd4, 3'd5}) ? C_BR : C_ILL;
            7'h6F: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // ALU code by mnemonic: and=0 or=1 add=2 passB=3 xor=4 sub=6 slt=7
    function automatic logic [3:0] alu_exp(input int cls, input logic [31:0] w);
        if (cls == C_LUI) return 4'd3;
        if (cls != C_R && cls != C_I) return 4'd2;
        case (w[14:12])
            3'd0: return (cls == C_R && w[30]) ? 4'd6 : 4'd2;
            3'd4: return 4'd4;
            3'd6: return 4'd1;
            3'd7: return 4'd0;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            default: return !lt;
        endcase
    endfunction

    task automatic cycle(input logic mr, input logic [18:0] e, input string tag);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk({tag, "_a"}, 32'(vec_a), 32'(e));
        chk({tag, "_b"}, 32'(vec_b), 32'(e));
        @(posedge clk);
    endtask

    task automatic retire();
        exp_instret = exp_instret + 1;
        #1;
        chk("instret_a", instret_a, exp_instret);
        chk("instret_b", 32'(instret_b), 32'(exp_instret[3:0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_a", 32'(vec_a), 32'h0);
        chk("rst_out_b", 32'(vec_b), 32'h0);
        chk("rst_cnt_a", instret_a, 32'h0);
        chk("rst_cnt_b", 32'(instret_b), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("idle_a", 32'(vec_a), 32'h0);
        chk("idle_b", 32'(vec_b), 32'h0);
        @(posedge clk);
        exp_instret = 0;
    endtask

    task automatic run_inst(input logic [31:0] w, input logic eq, input logic lt,
                            input int wf, input int wm, input bit abort, output bit trapped);
        int          cls;
        logic [3:0]  alu;
        logic [18:0] e;
        logic        lw;
        cls = classify(w);
        alu = alu_exp(cls, w);
        lw = (cls == C_LW);
        trapped = 1'b0;
        inst = w;
        BrEq = eq;
        BrLt = lt;
        for (int i = 0; i <= wf; i++)
            cycle(i == wf, ev(1, 1, i == wf, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, 2'd0, 0), "fetch");
        cycle(1'($urandom % 2), 19'h0, "decode");
        if (cls == C_ILL) begin
            trapped = 1'b1;
            for (int i = 0; i < 3; i++)
                cycle(1'($urandom % 2), ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, 2'd0, 1), "trap");
            chk("trap_cnt", instret_a, exp_instret);
            return;
        end
        case (cls)
            C_R:   e = ev(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, alu, 0, 2'd0, 0);
            C_SW:  e = ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, alu, 0, 2'd0, 0);
            C_LUI: e = ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, alu, 0, 2'd0, 0);
            C_BR:  e = ev(0, 0, 0, 0, 1, br_taken(w[14:12], eq, lt), 1, 1, 3'd3, alu, 0, 2'd0, 0);
            C_JAL: e = ev(0, 0, 0, 0, 1, 1, 1, 1, 3'd4, alu, 1, 2'd2, 0);
            default: e = ev(0, 0, 0, 0, 0, 0, 0, 1, 3'd0, alu, 0, 2'd0, 0);
        endcase
        cycle(1'($urandom % 2), e, "exec");
        if (cls == C_BR || cls == C_JAL) begin
            retire();
            return;
        end
        if (cls == C_LW || cls == C_SW) begin
            if (abort) begin
                cycle(1'b0, ev(1, lw, 0, 0, 0, 0, 0, 1, lw ? 3'd0 : 3'd1, 4'd2, 0, 2'd0, 0), "mem_wait");
                do_reset();
                return;
            end
            for (int i = 0; i <= wm; i++)
                cycle(i == wm, ev(1, lw, 0, lw && i == wm, !lw && i == wm, 0, 0, 1,
                                  lw ? 3'd0 : 3'd1, 4'd2, 0, 2'd0, 0), "mem");
            if (!lw) begin
                retire();
                return;
            end
        end
        cycle(1'($urandom % 2), ev(0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 4'd0, 1, lw ? 2'd0 : 2'd1, 0), "wb");
        retire();
    endtask

    function automatic logic [31:0] gen(input int k);
        logic [31:0] w;
        logic [2:0]  f3l [5] = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd2};
        logic [2:0]  brl [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
        int          r;
        w = $urandom;
        r = $urandom % 6;
        case (k)
            0: w = (r == 5) ? {7'h20, w[24:15], 3'd0, w[11:7], 7'h33}
                            : {7'h00, w[24:15], f3l[r % 5], w[11:7], 7'h33};
            1: w = {w[31:15], f3l[r % 5], w[11:7], 7'h13};
            2: w = {w[31:15], 3'd2, w[11:7], 7'h03};
            3: w = {w[31:15], 3'd2, w[11:7], 7'h23};
            4: w = {w[31:7], 7'h37};
            5: w = {w[31:15], brl[r % 4], w[11:7], 7'h63};
            default: w = {w[31:7], 7'h6F};
        endcase
        return w;
    endfunction

    initial begin
        bit trapped;
        do_reset();
        run_inst(32'h00500093, 0, 0, 0, 0, 0, trapped);  // addi
        run_inst(32'h002081B3, 0, 0, 0, 0, 0, trapped);  // add
        run_inst(32'h402081B3, 0, 0, 0, 0, 0, trapped);  // sub
        chk("three_retired", instret_a, 32'd3);
        run_inst(32'h0000A103, 0, 0, 2, 2, 0, trapped);  // lw with waits
        run_inst(32'h00208063, 1, 0, 0, 0, 0, trapped);  // beq taken
        run_inst(32'h00208063, 0, 0, 0, 0, 0, trapped);  // beq not taken
        run_inst(32'h0020D063, 0, 1, 0, 0, 0, trapped);  // bge, lt
        run_inst(32'h0000006F, 0, 0, 0, 0, 0, trapped);  // jal
        run_inst(32'h0020A023, 0, 0, 0, 1, 0, trapped);  // sw
        run_inst(32'h0020A023, 0, 0, 1, 3, 1, trapped);  // sw, reset mid-MEM
        chk("abort_cnt", instret_a, 32'd0);
        run_inst(32'h00000000, 0, 0, 0, 0, 0, trapped);
        chk("trap_ill", 32'(ill_a), 32'd1);
        do_reset();
        run_inst(32'h022081B3, 0, 0, 1, 0, 0, trapped);
        do_reset();
        for (int n = 0; n < 150; n++) begin
            logic [31:0] w;
            w = ($urandom % 20 == 0) ? 32'($urandom) : gen(int'($urandom % 7));
            run_inst(w, 1'($urandom % 2), 1'($urandom % 2), int'($urandom % 3), int'($urandom % 3), 0, trapped);
            if (trapped) do_reset();
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core, the sequential successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and write-back over a shared instruction/data memory port with a valid/ready handshake, and drives the datapath enables and selects. It also extends decode to R/I ALU ops, branches and JAL, flags illegal encodings, and counts retired instructions.

## Interface
- `ALUSEL_W`, default 4: width of `ALUSel`. Must be ≥4.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction register contents, valid from DECODE onward.
- `BrEq` in 1: rs1 == rs2, from the datapath comparator.
- `BrLt` in 1: rs1 < rs2 (signed), from the datapath comparator.
- `mem_ready` in 1: memory has completed the current access.
- `mem_valid` out 1: memory request.
- `MemRW` out 1: 1 = read, 0 = write.
- `IRWrite` out 1: load the instruction register.
- `MDRWrite` out 1: load the memory data register.
- `PCWrite` out 1: update the PC.
- `PCSel` out 1: 0 = PC+4, 1 = ALU result.
- `Asel` out 1: 0 = rs1, 1 = PC.
- `Bsel` out 1: 0 = rs2, 1 = immediate.
- `ImmSel` out 3: 000 = I, 001 = S, 010 = U, 011 = B, 100 = J.
- `ALUSel` out ALUSEL_W: 0000 = and, 0001 = or, 0010 = add, 0011 = pass B, 0100 = xor, 0110 = sub, 0111 = slt.
- `RegWEn` out 1: register-file write enable.
- `WBSel` out 2: 00 = MDR, 01 = ALU, 10 = PC+4.
- `illegal` out 1: sticky illegal-instruction flag.
- `instret` out CNT_W: count of retired instructions.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, WB, TRAP (registered state).
- **Default outputs:** every output not listed for a state is 0. No output is ever driven to x.
- **FETCH:**
  - Assert `mem_valid=1`, `MemRW=1`.
  - Hold until `mem_ready`. In the `mem_ready` cycle pulse `IRWrite=1`, then go to DECODE.
- **DECODE:** one cycle, no enables asserted.
  - Legal opcode/funct go to EXEC.
  - Anything else goes to TRAP.
- **Legal set:**
  - R-type (0110011), funct7 0000000: add/xor/or/and/slt. funct7 0100000: sub.
  - I-ALU (0010011): addi/xori/ori/andi/slti.
  - lw (0000011/010), sw (0100011/010).
  - lui (0110111).
  - beq/bne/blt/bge (1100011, funct3 000/001/100/101).
  - jal (1101111).
- **EXEC:**
  - R-type: `Bsel=0`, `ALUSel` per funct, go to WB.
  - I-ALU, lw: `Bsel=1`, `ImmSel=000`, `ALUSel=0010` for lw and per funct for I-ALU. I-ALU goes to WB; lw goes to MEM.
  - sw: `Bsel=1`, `ImmSel=001`, `ALUSel=0010`, go to MEM.
  - lui: `Bsel=1`, `ImmSel=010`, `ALUSel=0011`, go to WB.
  - Branch: `Asel=1`, `Bsel=1`, `ImmSel=011`, `ALUSel=0010`, `PCWrite=1`. `PCSel` = taken (beq: BrEq; bne: !BrEq; blt: BrLt; bge: !BrLt). Retire, go to FETCH.
  - jal: `Asel=1`, `Bsel=1`, `ImmSel=100`, `ALUSel=0010`, `PCWrite=1`, `PCSel=1`, `RegWEn=1`, `WBSel=10`. Retire, go to FETCH.
- **MEM:**
  - Assert `mem_valid=1`, `Bsel=1`, `ALUSel=0010`, and `ImmSel` as in EXEC. `MemRW=1` for lw, 0 for sw.
  - Hold until `mem_ready`.
  - lw: on ready pulse `MDRWrite`, go to WB.
  - sw: on ready assert `PCWrite=1`, `PCSel=0`, retire, go to FETCH.
- **WB:** `RegWEn=1`, `WBSel` = 00 (lw) or 01 (others), `PCWrite=1`, `PCSel=0`. Retire, go to FETCH.
- **TRAP:** `illegal=1`, all enables 0, absorbing. Left only by reset.
- **Retire:** `instret` increments by 1 at the retiring edge. It wraps from 2^CNT_W−1 to 0.

## Timing
- **Reset:** state = FETCH, `instret=0`, `illegal=0`. All other outputs take their FETCH values, so `mem_valid` and `MemRW` are 1 one cycle after deassertion.
- **Outputs:** Moore on state, except the handshake-qualified pulses `IRWrite`, `MDRWrite`, MEM-state `PCWrite`, and the branch `PCSel`.
- **Latency with zero wait states** (`mem_ready` high on the first request cycle):
  - R/I/lui, sw: 4 cycles.
  - lw: 5 cycles.
  - Branch, jal: 3 cycles.
- **Wait states:** each wait cycle adds 1 cycle in FETCH or MEM.
- **Handshake:**
  - `mem_valid` and `MemRW` stay stable until `mem_ready` is sampled high.
  - `mem_ready` while `mem_valid=0` is ignored.
- **Reset mid-operation:** asynchronous return to the reset values. In-flight enables drop immediately and `instret` clears.

## Test plan
- **addi, then add, then sub (zero-wait memory)** -> each takes 4 cycles. WB shows `RegWEn=1`, `WBSel=01`. `ALUSel` is 0010, 0010, 0110. `instret=3`.
- **lw with `mem_ready` delayed 2 cycles in both FETCH and MEM** -> 9 cycles total. `MDRWrite` pulses once. WB shows `WBSel=00`. `mem_valid` is held throughout each wait.
- **beq** -> with BrEq=1, `PCSel=1`; with BrEq=0, `PCSel=0`. bge with BrLt=1 -> `PCSel=0`. Each takes 3 cycles with `RegWEn=0`.
- **jal** -> in EXEC, `RegWEn=1`, `WBSel=10`, `PCSel=1`, `ImmSel=100`.
- **Illegal encodings** (inst=0x00000000, R-type with funct7=0000001) -> TRAP after DECODE. `illegal=1` and stays set. No `PCWrite`/`RegWEn`/`mem_valid` from then on. `instret` unchanged.
- **`rst_n` low mid-MEM of a sw** -> `mem_valid` drops asynchronously and no `PCWrite` occurs. After release: FETCH, `instret=0`. With CNT_W=4, 16 retirements -> `instret` wraps to 0.
